masked_4stage_bv8_inv_stage3: RTL and testbench

Third stage of the masked 4-stage GF(2^8) inverter; sits directly downstream of stage 2. Consumes the masked GF(2^2) value theta (cycle t2) and the two masked GF(2^4) products at t3. It produces the two masked output nibbles at t4 by scaling each GF(2^2) half of each product by theta. The block uses four 2-bit HPC1 multipliers that share one refreshed theta operand, plus a valid-tag pipeline.

---
 rtl/masked_4stage_bv8_inv_stage3.sv | 179 +++++++++++++++++
 tb/tb_masked_4stage_bv8_inv_stage3.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/masked_4stage_bv8_inv_stage3.sv
`default_nettype none
// ---------------------------------------------------------------------------
// masked_4stage_bv8_inv_stage3 : masked GF(2^8) inverter stage 3, theta scaling
// of two masked GF(2^4) products; valid tag enabled by MASKED_INV_STAGE3_VALID_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------

module masked_zero #(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 2
) (
    input  logic [NUM_SHARES-2:0][BIT_WIDTH-1:0] in_random,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] out_zero
);
    logic [BIT_WIDTH-1:0] w_last;

    // Last share closes the sum so all shares XOR to zero.
    for (genvar b = 0; b < BIT_WIDTH; b++) begin : g_bit
        localparam logic [BIT_WIDTH-1:0] SEL = BIT_WIDTH'(1) << b;
        assign w_last[b] = ^(in_random & {(NUM_SHARES-1){SEL}});
    end

    assign out_zero = {w_last, in_random};
endmodule

module masked_hpc1_mul #(
    parameter  int NUM_SHARES = 2,
    localparam int NUM_QUAD   = NUM_SHARES * (NUM_SHARES - 1) / 2
) (
    input  logic                        in_clock,
    input  logic                        in_reset,
    input  logic [NUM_SHARES-1:0][1:0]  in_a,
    input  logic [NUM_SHARES-1:0][1:0]  in_b,
    input  logic [NUM_QUAD-1:0][1:0]    in_p,
    output logic [NUM_SHARES-1:0][1:0]  out_c
);
    // Normal-basis GF(2^2) product; 2'b11 is the unit.
    function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
        logic w_s;
        w_s = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ w_s, (a[0] & b[0]) ^ w_s};
    endfunction

    function automatic int pair_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * NUM_SHARES - lo * (lo + 1) / 2 + hi - lo - 1;
    endfunction

    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][1:0] w_term;
    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][1:0] r_term;

    for (genvar i = 0; i < NUM_SHARES; i++) begin : g_row
        for (genvar j = 0; j < NUM_SHARES; j++) begin : g_col
            if (i == j) begin : g_diag
                assign w_term[i][j] = gf2_mul(in_a[i], in_b[i]);
            end else begin : g_cross
                // Cross terms are masked before the register that isolates them.
                assign w_term[i][j] = gf2_mul(in_a[i], in_b[j]) ^ in_p[pair_idx(i, j)];
            end
        end
        assign out_c[i] = {^(r_term[i] & {NUM_SHARES{2'b10}}),
                           ^(r_term[i] & {NUM_SHARES{2'b01}})};
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_term <= '0;
        end else begin
            r_term <= w_term;
        end
    end
endmodule

module masked_4stage_bv8_inv_stage3 #(
    parameter  int NUM_SHARES = 2,
    localparam int NUM_ZERO   = NUM_SHARES - 1,
    localparam int NUM_QUAD   = NUM_SHARES * (NUM_SHARES - 1) / 2,
    localparam int NUM_RANDOM = 2 * NUM_ZERO + 8 * NUM_QUAD
) (
    input  logic                        in_clock,
    input  logic                        in_reset,
    input  logic [NUM_SHARES-1:0][1:0]  in_theta_t2,
    input  logic [NUM_SHARES-1:0][3:0]  in_mul_a0_t3,
    input  logic [NUM_SHARES-1:0][3:0]  in_mul_a1_t3,
    input  logic [NUM_RANDOM-1:0]       in_random,
`ifdef MASKED_INV_STAGE3_VALID_EN
    input  logic                        in_valid_t2,
    output logic                        out_valid_t4,
`endif
    output logic [NUM_SHARES-1:0][3:0]  out_b0_t4,
    output logic [NUM_SHARES-1:0][3:0]  out_b1_t4
);
    localparam int PW = 2 * NUM_QUAD;

    logic [NUM_ZERO-1:0][1:0]   w_joint_raw;
    logic [NUM_SHARES-1:0][1:0] w_joint_r;
    logic [NUM_QUAD-1:0][1:0]   w_p_b0l, w_p_b0h, w_p_b1l, w_p_b1h;
    logic [NUM_QUAD-1:0][1:0]   r_p_b0l, r_p_b0h, r_p_b1l, r_p_b1h;
    logic [NUM_SHARES-1:0][1:0] r_theta_t3;
    logic [NUM_SHARES-1:0][1:0] w_m0h, w_m0l, w_m1h, w_m1l;
    logic [NUM_SHARES-1:0][1:0] w_b0h, w_b0l, w_b1h, w_b1l;

    assign w_joint_raw = in_random[4*PW +: 2*NUM_ZERO];
    assign w_p_b0l     = in_random[0*PW +: PW];
    assign w_p_b0h     = in_random[1*PW +: PW];
    assign w_p_b1l     = in_random[2*PW +: PW];
    assign w_p_b1h     = in_random[3*PW +: PW];

    masked_zero #(
        .NUM_SHARES (NUM_SHARES),
        .BIT_WIDTH  (2)
    ) u_zero (
        .in_random  (w_joint_raw),
        .out_zero   (w_joint_r)
    );

    // One refresh of theta serves all four multipliers; the gadget randomness
    // drawn in the same cycle travels with that element.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_theta_t3 <= '0;
            r_p_b0l    <= '0;
            r_p_b0h    <= '0;
            r_p_b1l    <= '0;
            r_p_b1h    <= '0;
        end else begin
            r_theta_t3 <= in_theta_t2 ^ w_joint_r;
            r_p_b0l    <= w_p_b0l;
            r_p_b0h    <= w_p_b0h;
            r_p_b1l    <= w_p_b1l;
            r_p_b1h    <= w_p_b1h;
        end
    end

    for (genvar i = 0; i < NUM_SHARES; i++) begin : g_split
        assign w_m0h[i]     = in_mul_a0_t3[i][3:2];
        assign w_m0l[i]     = in_mul_a0_t3[i][1:0];
        assign w_m1h[i]     = in_mul_a1_t3[i][3:2];
        assign w_m1l[i]     = in_mul_a1_t3[i][1:0];
        assign out_b0_t4[i] = {w_b0h[i], w_b0l[i]};
        assign out_b1_t4[i] = {w_b1h[i], w_b1l[i]};
    end

    masked_hpc1_mul #(.NUM_SHARES(NUM_SHARES)) u_mul_b0l (
        .in_clock (in_clock), .in_reset (in_reset),
        .in_a (w_m0l), .in_b (r_theta_t3), .in_p (r_p_b0l), .out_c (w_b0l)
    );
    masked_hpc1_mul #(.NUM_SHARES(NUM_SHARES)) u_mul_b0h (
        .in_clock (in_clock), .in_reset (in_reset),
        .in_a (w_m0h), .in_b (r_theta_t3), .in_p (r_p_b0h), .out_c (w_b0h)
    );
    masked_hpc1_mul #(.NUM_SHARES(NUM_SHARES)) u_mul_b1l (
        .in_clock (in_clock), .in_reset (in_reset),
        .in_a (w_m1l), .in_b (r_theta_t3), .in_p (r_p_b1l), .out_c (w_b1l)
    );
    masked_hpc1_mul #(.NUM_SHARES(NUM_SHARES)) u_mul_b1h (
        .in_clock (in_clock), .in_reset (in_reset),
        .in_a (w_m1h), .in_b (r_theta_t3), .in_p (r_p_b1h), .out_c (w_b1h)
    );

`ifdef MASKED_INV_STAGE3_VALID_EN
    logic [1:0] r_valid;

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= {r_valid[0], in_valid_t2};
        end
    end

    assign out_valid_t4 = r_valid[1];
`endif
endmodule

`default_nettype wire

// File: tb/tb_masked_4stage_bv8_inv_stage3.sv
`default_nettype none
// Scoreboard bench: 2- and 3-share instances fed the same unmasked stream, checked
// against a log/antilog GF(4) model after recombining the output shares.
module tb_masked_4stage_bv8_inv_stage3;
    localparam int R2 = 2 * 1 + 8 * 1;
    localparam int R3 = 2 * 2 + 8 * 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic v_in  = 1'b0;

    logic [1:0][1:0] th2;
    logic [1:0][3:0] a0_2, a1_2, b0_2, b1_2;
    logic [R2-1:0]   rnd2;
    logic [2:0][1:0] th3;
    logic [2:0][3:0] a0_3, a1_3, b0_3, b1_3;
    logic [R3-1:0]   rnd3;
`ifdef MASKED_INV_STAGE3_VALID_EN
    logic v2, v3;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    masked_4stage_bv8_inv_stage3 #(.NUM_SHARES(2)) dut2 (
        .in_clock(clk), .in_reset(rst_n), .in_theta_t2(th2),
        .in_mul_a0_t3(a0_2), .in_mul_a1_t3(a1_2), .in_random(rnd2),
`ifdef MASKED_INV_STAGE3_VALID_EN
        .in_valid_t2(v_in), .out_valid_t4(v2),
`endif
        .out_b0_t4(b0_2), .out_b1_t4(b1_2)
    );

    masked_4stage_bv8_inv_stage3 #(.NUM_SHARES(3)) dut3 (
        .in_clock(clk), .in_reset(rst_n), .in_theta_t2(th3),
        .in_mul_a0_t3(a0_3), .in_mul_a1_t3(a1_3), .in_random(rnd3),
`ifdef MASKED_INV_STAGE3_VALID_EN
        .in_valid_t2(v_in), .out_valid_t4(v3),
`endif
        .out_b0_t4(b0_3), .out_b1_t4(b1_3)
    );

    typedef struct {
        int         due;
        logic [3:0] e0;
        logic [3:0] e1;
        logic       v;
        logic       zp;
    } exp_t;

    exp_t        q[$];
    int          ncmp = 0;
    int          nfail = 0;
    logic [15:0] seen = '0;
    logic        release_now = 1'b0;
    logic [3:0]  pm0 = '0;
    logic [3:0]  pm1 = '0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        ncmp++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // GF(4) via discrete logs: 2'b11 = 1, 2'b01 = w, 2'b10 = w^2.
    function automatic logic [1:0] gmul(input logic [1:0] a, input logic [1:0] b);
        int         lg[4];
        logic [1:0] ex[3];
        lg = '{0, 1, 2, 0};
        ex = '{2'b11, 2'b01, 2'b10};
        if (a == 2'b00 || b == 2'b00) return 2'b00;
        return ex[(lg[a] + lg[b]) % 3];
    endfunction

    function automatic logic [3:0] scale(input logic [1:0] t, input logic [3:0] m);
        return {gmul(t, m[3:2]), gmul(t, m[1:0])};
    endfunction

    function automatic logic [1:0][3:0] sh2(input logic [3:0] v);
        logic [3:0] r0;
        r0 = 4'($urandom);
        return {v ^ r0, r0};
    endfunction

    function automatic logic [2:0][3:0] sh3(input logic [3:0] v);
        logic [3:0] r0, r1;
        r0 = 4'($urandom);
        r1 = 4'($urandom);
        return {v ^ r0 ^ r1, r1, r0};
    endfunction

    // Drives theta of the new element and the products of the previous one.
    task automatic step(input logic [1:0] t, input logic [3:0] m0, input logic [3:0] m1,
                        input logic v, input logic zp, input logic push);
        logic [1:0][3:0] s2;
        logic [2:0][3:0] s3;
        exp_t            e;
        @(negedge clk);
        s2   = sh2({2'b00, t});
        th2  = {s2[1][1:0], s2[0][1:0]};
        s3   = sh3({2'b00, t});
        th3  = {s3[2][1:0], s3[1][1:0], s3[0][1:0]};
        a0_2 = sh2(pm0);
        a1_2 = sh2(pm1);
        a0_3 = sh3(pm0);
        a1_3 = sh3(pm1);
        rnd2 = R2'($urandom);
        rnd3 = R3'($urandom);
        v_in = v;
        if (release_now) begin
            rst_n       = 1'b1;
            release_now = 1'b0;
        end
        if (push) begin
            e.due = cyc + 2;
            e.e0  = scale(t, m0);
            e.e1  = scale(t, m1);
`ifdef MASKED_INV_STAGE3_VALID_EN
            e.v   = v;
`else
            e.v   = 1'b1;
`endif
            e.zp  = zp;
            q.push_back(e);
        end
        pm0 = m0;
        pm1 = m1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_n2"}, {b0_2, b1_2}, 16'h0);
        chk({nm, "_n3_b0"}, 16'(b0_3), 16'h0);
        chk({nm, "_n3_b1"}, 16'(b1_3), 16'h0);
`ifdef MASKED_INV_STAGE3_VALID_EN
        chk({nm, "_valid"}, 16'({v2, v3}), 16'h0);
`endif
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        logic ev;
        ev = 1'b0;
        while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            chk("stale_entry", 16'(e.due), 16'(cyc));
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e  = q.pop_front();
            ev = e.v;
            if (e.v) begin
                chk("b0_n2", 16'(b0_2[0] ^ b0_2[1]), 16'(e.e0));
                chk("b1_n2", 16'(b1_2[0] ^ b1_2[1]), 16'(e.e1));
                chk("b0_n3", 16'(b0_3[0] ^ b0_3[1] ^ b0_3[2]), 16'(e.e0));
                chk("b1_n3", 16'(b1_3[0] ^ b1_3[1] ^ b1_3[2]), 16'(e.e1));
            end
            if (e.zp) seen[b0_2[0]] = 1'b1;
        end
`ifdef MASKED_INV_STAGE3_VALID_EN
        chk("valid_n2", 16'(v2), 16'(ev));
        chk("valid_n3", 16'(v3), 16'(ev));
`endif
    end

    initial begin
        logic [3:0] pat;
        pat = 4'b1101;

        // Reset held with live, non-zero inputs.
        repeat (3) begin
            step(2'b11, 4'hF, 4'h9, 1'b1, 1'b0, 1'b0);
            #1;
            chk_zero("rst_hold");
        end

        release_now = 1'b1;
        step(2'b11, 4'hF, 4'($urandom), 1'b1, 1'b0, 1'b1);
        step(2'b11, 4'hA, 4'h5, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++)
            step(2'($urandom), 4'($urandom), 4'($urandom), pat[i], 1'b0, 1'b1);

        for (int i = 0; i < 100; i++)
            step(2'b00, 4'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 64; i++)
            step(2'($urandom), 4'($urandom), 4'($urandom), (i >= 16) || (i % 2 == 0), 1'b0, 1'b1);

        // Reset pulsed between edges: outputs clear at once, in-flight work is dropped.
        step(2'b11, 4'h6, 4'h3, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        q.delete();
        release_now = 1'b1;
        step(2'b11, 4'hF, 4'hC, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            step(2'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0, 1'b1);

        repeat (3) step(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("queue_drained", 16'(q.size()), 16'h0);
        chk("zero_share_varies", 16'($countones(seen) > 1), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

`default_nettype wire
